// File: rtl/riscv_trap_pkg.sv
// Shared decode constants, cause codes and sequencer state encoding for the trap sequencer.
// Pure definitions; no logic.
package riscv_trap_pkg;

   localparam logic [3:0] OP_BRANCH = 4'd0;
   localparam logic [3:0] OP_JAL    = 4'd1;
   localparam logic [3:0] OP_JALR   = 4'd2;
   localparam logic [3:0] OP_SYSTEM = 4'd3;

   localparam logic [3:0] SUB_ECALL  = 4'd0;
   localparam logic [3:0] SUB_EBREAK = 4'd1;
   localparam logic [3:0] SUB_MRET   = 4'd2;

   localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // Everything in a trap record except the pc-width fields.
   typedef struct packed {
      logic       valid;
      logic       ret;
      logic       is_interrupt;
      logic [3:0] cause;
      logic       ebreak_to_dbg;
      logic       async_cancel;
   } trap_kind_t;

endpackage

// File: rtl/riscv_irq_priority_encoder.sv
// Lowest-index-first priority encoder over the interrupt candidate vector.
// Purely combinational, no backpressure.
module riscv_irq_priority_encoder #(
   parameter int NUM_IRQ = 16
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [3:0]         index
);

   always_comb begin
      valid = 1'b0;
      index = 4'd0;
      // Walk downwards so the lowest set bit is the last writer.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            index = 4'(i);
         end
      end
   end

endmodule

// File: rtl/riscv_i32_trap_sequencer.sv
// Latches and prioritises IRQs, merges exec exceptions into one registered trap record (event N -> record N+1).
// After issuing, further traps are held off until trap_complete or the WAIT watchdog expires.
module riscv_i32_trap_sequencer
   import riscv_trap_pkg::*;
#(
   parameter int                 NUM_IRQ   = 16,
   parameter int                 PC_WIDTH  = 32,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
   parameter int                 TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_IRQ-1:0]  irq_in,
   input  logic [NUM_IRQ-1:0]  irq_enable,
   input  logic                global_ie,
   input  logic                exec_valid,
   input  logic                exec_committed,
   input  logic [PC_WIDTH-1:0] exec_pc,
   input  logic [31:0]         exec_instruction,
   input  logic [3:0]          exec_op,
   input  logic [3:0]          exec_subop,
   input  logic                exec_illegal,
   input  logic                exec_illegal_pc,
   input  logic                branch_condition_met,
   input  logic                ebreak_to_dbg,
   input  logic                interrupt_ack,
   input  logic                trap_complete,
   output logic                interrupt_req,
   output logic [3:0]          interrupt_number,
   output logic                branch_taken,
   output logic                jalr,
   output logic                trap_valid,
   output logic                trap_ret,
   output logic                trap_is_interrupt,
   output logic [3:0]          trap_cause,
   output logic [PC_WIDTH-1:0] trap_pc,
   output logic [PC_WIDTH-1:0] trap_value,
   output logic                trap_ebreak_to_dbg,
   output logic                async_cancel,
   output logic                busy,
   output logic                timeout_err,
   output logic [NUM_IRQ-1:0]  irq_pending
);

   logic [1:0]          state;
   logic [15:0]         wait_cnt;
   logic [NUM_IRQ-1:0]  irq_hist;
   logic [NUM_IRQ-1:0]  irq_rise;
   logic [NUM_IRQ-1:0]  ack_clear;
   logic [NUM_IRQ-1:0]  pending_next;
   logic [NUM_IRQ-1:0]  cand;
   logic [NUM_IRQ-1:0]  sel_mask;
   logic                cand_vld;
   logic [3:0]          cand_idx;
   logic                in_idle;
   logic                ack_fire;
   logic                frozen_ok;
   logic                req_next;
   logic                take;
   logic                wait_done;
   logic                sys_commit;
   trap_kind_t          sel;
   logic [PC_WIDTH-1:0] sel_value;

   assign in_idle  = (state == ST_IDLE);
   assign busy     = !in_idle;
   assign irq_rise = irq_in & ~irq_hist;
   assign sel_mask = NUM_IRQ'(1) << interrupt_number;
   assign ack_fire = in_idle & interrupt_req & interrupt_ack;

   // Edge channels: a fresh rising edge beats the clear from a same-cycle ack.
   assign ack_clear    = ack_fire ? (sel_mask & EDGE_MASK) : '0;
   assign pending_next = (EDGE_MASK & ((irq_pending & ~ack_clear) | irq_rise))
                       | (~EDGE_MASK & irq_in);

   assign cand = (global_ie && in_idle) ? (irq_pending & irq_enable) : '0;

   riscv_irq_priority_encoder #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio (
      .req   (cand),
      .valid (cand_vld),
      .index (cand_idx)
   );

   // While a request is up the channel is frozen; it only survives if that channel stays eligible.
   assign frozen_ok = |(sel_mask & cand);
   assign req_next  = !take && (interrupt_req ? frozen_ok : cand_vld);

   always_comb begin
      branch_taken = 1'b0;
      jalr         = 1'b0;
      if (exec_committed) begin
         case (exec_op)
            OP_BRANCH: branch_taken = branch_condition_met;
            OP_JAL:    branch_taken = 1'b1;
            OP_JALR: begin
               branch_taken = 1'b1;
               jalr         = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sys_commit = exec_valid && exec_committed && (exec_op == OP_SYSTEM);

   always_comb begin
      sel       = '0;
      sel_value = '0;
      if (ack_fire) begin
         sel.valid        = 1'b1;
         sel.is_interrupt = 1'b1;
         sel.cause        = interrupt_number;
         sel.async_cancel = 1'b1;
         sel_value        = exec_pc;
      end else if (exec_valid && exec_illegal_pc) begin
         sel.valid = 1'b1;
         sel.cause = CAUSE_MISALIGNED;
         sel_value = exec_pc;
      end else if (exec_valid && exec_illegal) begin
         sel.valid = 1'b1;
         sel.cause = CAUSE_ILLEGAL;
         sel_value = PC_WIDTH'(exec_instruction);
      end else if (sys_commit && exec_subop == SUB_ECALL) begin
         sel.valid = 1'b1;
         sel.cause = CAUSE_ECALL_M;
      end else if (sys_commit && exec_subop == SUB_EBREAK) begin
         sel.valid         = 1'b1;
         sel.cause         = CAUSE_BREAKPOINT;
         sel.ebreak_to_dbg = ebreak_to_dbg;
         sel_value         = exec_pc;
      end else if (sys_commit && exec_subop == SUB_MRET) begin
         sel.ret = 1'b1;
      end
   end

   assign take      = in_idle && (sel.valid || sel.ret);
   assign wait_done = trap_complete || (wait_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state              <= ST_IDLE;
         wait_cnt           <= '0;
         irq_hist           <= '1;
         irq_pending        <= '0;
         interrupt_req      <= 1'b0;
         interrupt_number   <= 4'd0;
         trap_valid         <= 1'b0;
         trap_ret           <= 1'b0;
         trap_is_interrupt  <= 1'b0;
         trap_cause         <= 4'd0;
         trap_pc            <= '0;
         trap_value         <= '0;
         trap_ebreak_to_dbg <= 1'b0;
         async_cancel       <= 1'b0;
         timeout_err        <= 1'b0;
      end else begin
         irq_hist      <= irq_in;
         irq_pending   <= pending_next;
         interrupt_req <= req_next;
         if (!interrupt_req) begin
            interrupt_number <= cand_idx;
         end
         trap_valid  <= 1'b0;
         trap_ret    <= 1'b0;
         timeout_err <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (take) begin
                  state              <= ST_ISSUE;
                  trap_valid         <= sel.valid;
                  trap_ret           <= sel.ret;
                  trap_is_interrupt  <= sel.is_interrupt;
                  trap_cause         <= sel.cause;
                  trap_pc            <= exec_pc;
                  trap_value         <= sel_value;
                  trap_ebreak_to_dbg <= sel.ebreak_to_dbg;
                  async_cancel       <= sel.async_cancel;
               end
            end
            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               if (wait_cnt != 16'hFFFF) begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
               if (wait_done) begin
                  state              <= ST_IDLE;
                  timeout_err        <= !trap_complete;
                  trap_is_interrupt  <= 1'b0;
                  trap_cause         <= 4'd0;
                  trap_pc            <= '0;
                  trap_value         <= '0;
                  trap_ebreak_to_dbg <= 1'b0;
                  async_cancel       <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_i32_trap_sequencer.sv
// Randomised scoreboard bench for riscv_i32_trap_sequencer with a behavioural model of pending/priority and trap rules.
module tb_riscv_i32_trap_sequencer;

   localparam int          TO     = 255;
   localparam logic [15:0] EMASK  = 16'h0086;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] irq_in, irq_enable;
   logic        global_ie, exec_valid, exec_committed;
   logic [31:0] exec_pc, exec_instruction;
   logic [3:0]  exec_op, exec_subop;
   logic        exec_illegal, exec_illegal_pc, branch_condition_met, ebreak_to_dbg;
   logic        interrupt_ack, trap_complete;
   logic        interrupt_req;
   logic [3:0]  interrupt_number;
   logic        branch_taken, jalr, trap_valid, trap_ret, trap_is_interrupt;
   logic [3:0]  trap_cause;
   logic [31:0] trap_pc, trap_value;
   logic        trap_ebreak_to_dbg, async_cancel, busy, timeout_err;
   logic [15:0] irq_pending;

   always #5 clk = ~clk;

   riscv_i32_trap_sequencer #(
      .NUM_IRQ(16), .PC_WIDTH(32), .EDGE_MASK(EMASK), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .irq_enable(irq_enable),
      .global_ie(global_ie), .exec_valid(exec_valid), .exec_committed(exec_committed),
      .exec_pc(exec_pc), .exec_instruction(exec_instruction), .exec_op(exec_op),
      .exec_subop(exec_subop), .exec_illegal(exec_illegal), .exec_illegal_pc(exec_illegal_pc),
      .branch_condition_met(branch_condition_met), .ebreak_to_dbg(ebreak_to_dbg),
      .interrupt_ack(interrupt_ack), .trap_complete(trap_complete),
      .interrupt_req(interrupt_req), .interrupt_number(interrupt_number),
      .branch_taken(branch_taken), .jalr(jalr), .trap_valid(trap_valid), .trap_ret(trap_ret),
      .trap_is_interrupt(trap_is_interrupt), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .trap_value(trap_value), .trap_ebreak_to_dbg(trap_ebreak_to_dbg),
      .async_cancel(async_cancel), .busy(busy), .timeout_err(timeout_err),
      .irq_pending(irq_pending)
   );

   typedef struct packed {
      logic        ret;
      logic        is_int;
      logic [3:0]  cause;
      logic [31:0] pc;
      logic [31:0] value;
      logic        dbg;
      logic        cancel;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] edge_m   = EMASK;
   logic [15:0] lines_m  = '0;
   logic [15:0] pend_m   = '0;
   logic [15:0] en_m     = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int lowest(input logic [15:0] c);
      for (int i = 0; i < 16; i++) if (c[i]) return i;
      return -1;
   endfunction

   task automatic clear_exec();
      exec_valid = 0; exec_committed = 0; exec_op = 4'd4; exec_subop = 4'd0;
      exec_illegal = 0; exec_illegal_pc = 0; branch_condition_met = 0; ebreak_to_dbg = 0;
   endtask

   // Scoreboard monitor: every trap/mret pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && (trap_valid || trap_ret)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_trap", 32'({trap_valid, trap_ret}), 32'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("trap_valid",   32'(trap_valid),         32'(!mon_e.ret));
            check("trap_ret",     32'(trap_ret),           32'(mon_e.ret));
            check("trap_is_int",  32'(trap_is_interrupt),  32'(mon_e.is_int));
            check("trap_cause",   32'(trap_cause),         32'(mon_e.cause));
            check("trap_pc",      trap_pc,                 mon_e.pc);
            check("trap_value",   trap_value,              mon_e.value);
            check("trap_dbg",     32'(trap_ebreak_to_dbg), 32'(mon_e.dbg));
            check("async_cancel", 32'(async_cancel),       32'(mon_e.cancel));
         end
      end
   end

   task automatic check_req();
      int lo;
      lo = lowest(pend_m & en_m);
      check("irq_req", 32'(interrupt_req), 32'(lo >= 0));
      if (lo >= 0) check("irq_num", 32'(interrupt_number), 32'(lo));
   endtask

   // Lines/enables only change with global_ie low so the next request is a fresh lowest-index pick.
   task automatic set_irq(input logic [15:0] nl, input logic [15:0] ne);
      global_ie = 0;
      tick();
      for (int i = 0; i < 16; i++) begin
         if (edge_m[i]) begin
            if (!lines_m[i] && nl[i]) pend_m[i] = 1'b1;
         end else begin
            pend_m[i] = nl[i];
         end
      end
      lines_m = nl; en_m = ne; irq_in = nl; irq_enable = ne;
      tick(); tick();
      global_ie = 1;
      tick(); tick(); tick();
      check("pending", 32'(irq_pending), 32'(pend_m));
      check_req();
   endtask

   // delay < 0: never complete, expect the watchdog.
   task automatic finish_trap(input int delay);
      int cnt;
      check("busy_issue", 32'(busy), 32'(1));
      if (delay < 0) begin
         cnt = 0;
         while (!timeout_err && cnt < 400) begin
            tick();
            cnt++;
         end
         check("timeout_cycles", 32'(cnt), 32'(TO + 1));
         check("busy_after_timeout", 32'(busy), 32'(0));
         tick();
         check("timeout_pulse_width", 32'(timeout_err), 32'(0));
         return;
      end
      trap_complete = 1;
      tick();
      trap_complete = 0;
      check("complete_in_issue_ignored", 32'(busy), 32'(1));
      for (int i = 0; i < delay; i++) tick();
      check("busy_wait", 32'(busy), 32'(1));
      check("req_in_wait", 32'(interrupt_req), 32'(0));
      trap_complete = 1;
      tick();
      trap_complete = 0;
      check("busy_released", 32'(busy), 32'(0));
      check("no_timeout", 32'(timeout_err), 32'(0));
   endtask

   // mode 0: no exec activity, 1: random exec activity, 2: committed ecall alongside the ack.
   task automatic serve(input int force_num, input int mode, input int delay);
      int   lo;
      exp_t e;
      tick(); tick(); tick();
      lo = (force_num >= 0) ? force_num : lowest(pend_m & en_m);
      if (force_num < 0) check_req();
      else check("irq_num_forced", 32'(interrupt_number), 32'(force_num));
      if (lo < 0) return;
      exec_pc = $urandom & 32'hFFFF_FFFC;
      if (mode == 1) begin
         exec_valid = 1'($urandom); exec_committed = 1'($urandom);
         exec_op = 4'($urandom_range(0, 4)); exec_subop = 4'($urandom_range(0, 3));
         exec_illegal = 1'($urandom); exec_illegal_pc = 1'($urandom);
         exec_instruction = $urandom;
      end else if (mode == 2) begin
         exec_valid = 1; exec_committed = 1; exec_op = 4'd3; exec_subop = 4'd0;
      end
      interrupt_ack = 1;
      e = '0;
      e.is_int = 1; e.cause = 4'(lo); e.pc = exec_pc; e.value = exec_pc; e.cancel = 1;
      exp_q.push_back(e);
      tick();
      interrupt_ack = 0;
      clear_exec();
      if (edge_m[lo]) pend_m[lo] = 1'b0;
      check("pending_after_ack", 32'(irq_pending[lo]), 32'(pend_m[lo]));
      finish_trap(delay);
   endtask

   task automatic exec_event(input logic v, input logic c, input logic [3:0] op, input logic [3:0] sub,
                             input logic ill, input logic ipc, input logic bc, input logic dbg,
                             input logic [31:0] pc, input logic [31:0] ins, input int delay);
      exp_t e;
      bit   has;
      exec_valid = v; exec_committed = c; exec_op = op; exec_subop = sub;
      exec_illegal = ill; exec_illegal_pc = ipc; branch_condition_met = bc; ebreak_to_dbg = dbg;
      exec_pc = pc; exec_instruction = ins;
      #1;
      check("branch_taken", 32'(branch_taken),
            32'(c && ((op == 4'd0) ? bc : (op == 4'd1 || op == 4'd2))));
      check("jalr", 32'(jalr), 32'(c && op == 4'd2));
      e = '0; e.pc = pc; has = 1;
      if (v && ipc)                                    e.value = pc;
      else if (v && ill) begin e.cause = 4'd2;         e.value = ins; end
      else if (v && c && op == 4'd3 && sub == 4'd0)    e.cause = 4'd11;
      else if (v && c && op == 4'd3 && sub == 4'd1) begin
         e.cause = 4'd3; e.value = pc; e.dbg = dbg;
      end
      else if (v && c && op == 4'd3 && sub == 4'd2)    e.ret = 1;
      else has = 0;
      if (has) exp_q.push_back(e);
      tick();
      clear_exec();
      if (has) finish_trap(delay);
      else check("no_trap_idle", 32'(busy), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

   initial begin
      reset_n = 0; irq_in = '0; irq_enable = '0; global_ie = 0;
      exec_pc = '0; exec_instruction = '0; interrupt_ack = 0; trap_complete = 0;
      clear_exec();
      tick(); tick(); tick();
      check("rst_busy",    32'(busy),          32'(0));
      check("rst_req",     32'(interrupt_req), 32'(0));
      check("rst_pending", 32'(irq_pending),   32'(0));
      check("rst_timeout", 32'(timeout_err),   32'(0));
      check("rst_cancel",  32'(async_cancel),  32'(0));
      reset_n = 1;
      tick();

      exec_event(1, 0, 4'd4, 4'd0, 1, 0, 0, 0, 32'h100, 32'hFFFF_FFFF, 2);
      exec_event(1, 1, 4'd3, 4'd1, 0, 0, 0, 1, 32'h204, 32'h0010_0073, 1);
      exec_event(1, 1, 4'd3, 4'd0, 0, 0, 0, 0, 32'h208, 32'h0000_0073, 0);
      exec_event(1, 1, 4'd3, 4'd0, 1, 1, 0, 0, 32'h20A, 32'h0000_0073, 3);
      exec_event(1, 1, 4'd0, 4'd0, 0, 0, 1, 0, 32'h300, 32'h0, 0);
      exec_event(1, 1, 4'd2, 4'd0, 0, 0, 0, 0, 32'h304, 32'h0, 0);
      exec_event(1, 0, 4'd1, 4'd0, 0, 0, 0, 0, 32'h308, 32'h0, 0);

      // Level irq 5, then edge irq 2 rising while 5 is already requested: number stays frozen.
      set_irq(16'h0020, 16'hFFFF);
      irq_in = 16'h0024; lines_m = 16'h0024; pend_m[2] = 1'b1;
      serve(5, 0, 2);
      set_irq(16'h0000, 16'hFFFF);
      serve(-1, 0, 1);

      // Edge 2 and 7 together: 2 first, 7 requested after completion.
      set_irq(16'h0084, 16'hFFFF);
      serve(-1, 0, 0);
      serve(-1, 0, 2);
      check("edge_pending_drained", 32'(irq_pending), 32'(0));

      // Interrupt ack beats a committed ecall in the same cycle.
      set_irq(16'h0008, 16'hFFFF);
      serve(-1, 2, 1);
      set_irq(16'h0000, 16'hFFFF);

      // mret with no completion -> watchdog.
      exec_event(1, 1, 4'd3, 4'd2, 0, 0, 0, 0, 32'h400, 32'h3020_0073, -1);

      // Reset mid-WAIT with edge irq 1 held high.
      set_irq(16'h0002, 16'hFFFF);
      interrupt_ack = 1;
      exec_pc = 32'h500;
      mon_e = '0;
      exp_q.push_back('{ret: 1'b0, is_int: 1'b1, cause: 4'd1, pc: 32'h500, value: 32'h500,
                        dbg: 1'b0, cancel: 1'b1});
      tick();
      interrupt_ack = 0;
      tick(); tick();
      check("pre_reset_busy", 32'(busy), 32'(1));
      reset_n = 0;
      tick(); tick();
      reset_n = 1;
      pend_m = '0;
      tick(); tick(); tick(); tick();
      check("post_reset_busy",    32'(busy),              32'(0));
      check("post_reset_pending", 32'(irq_pending),       32'(0));
      check("post_reset_req",     32'(interrupt_req),     32'(0));
      check("post_reset_cancel",  32'(async_cancel),      32'(0));
      check("post_reset_is_int",  32'(trap_is_interrupt), 32'(0));
      set_irq(16'h0000, 16'hFFFF);
      set_irq(16'h0002, 16'hFFFF);
      serve(-1, 1, 1);
      set_irq(16'h0000, 16'hFFFF);

      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 3))
            0: set_irq(16'($urandom & $urandom), 16'($urandom | $urandom));
            1: serve(-1, 1, int'($urandom_range(0, 4)));
            default: exec_event(1'($urandom_range(0, 3) != 0), 1'($urandom),
                                4'($urandom_range(0, 4)), 4'($urandom_range(0, 3)),
                                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                                1'($urandom), 1'($urandom), $urandom, $urandom,
                                int'($urandom_range(0, 3)));
         endcase
      end

      tick(); tick();
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
